// File: rtl/stoch_decode_mat.sv
// stoch_decode_mat: per-element windowed ones counter turning stochastic bitstreams into binary counts
module stoch_decode_mat #(
  parameter int NUM_ROWS    = 2,
  parameter int NUM_COLS    = 2,
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                                                  CLK,
  input  logic                                                  nRST,
  input  logic                                                  start,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                     A,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0]      Y,
  output logic                                                  valid,
  output logic                                                  busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t                                           state_q;
  logic [WINDOW_LOG2-1:0]                           cnt_q;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][WINDOW_LOG2:0] acc_q, acc_d, y_q;
  logic                                             valid_q, busy_q;
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NUM_ROWS; i++)
      for (int j = 0; j < NUM_COLS; j++)
        acc_d[i][j] = acc_q[i][j] + {{WINDOW_LOG2{1'b0}}, A[i][j]};
  end
  // The window counter is all ones on the edge taking the final sample
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          state_q <= ACCUM;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          acc_q   <= '0;
        end
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + 1'b1;
        if (&cnt_q) begin
          y_q     <= acc_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      end
    end
  end
  assign Y     = y_q;
  assign valid = valid_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_stoch_decode_mat.sv
// tb_stoch_decode_mat: table-driven and randomized checks of the windowed stochastic decoder
module tb_stoch_decode_mat;
  logic                 CLK = 1'b0;
  logic                 nRST, start, start2;
  logic [1:0][1:0]      a;
  logic [1:0][1:0][4:0] y;
  logic                 valid, busy;
  logic [2:0][0:0]      a2;
  logic [2:0][0:0][1:0] y2;
  logic                 valid2, busy2;
  int                   passed = 0, total = 0;

  typedef struct {
    int kind[4];
    int ex[4];
    bit hold;
    int mid;
  } vec_t;
  vec_t vecs[6];

  always #5 CLK = ~CLK;

  stoch_decode_mat #(.NUM_ROWS(2), .NUM_COLS(2), .WINDOW_LOG2(4)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .A(a), .Y(y), .valid(valid), .busy(busy));

  stoch_decode_mat #(.NUM_ROWS(3), .NUM_COLS(1), .WINDOW_LOG2(1)) dut2 (
    .CLK(CLK), .nRST(nRST), .start(start2), .A(a2), .Y(y2), .valid(valid2), .busy(busy2));

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // kinds: 0 zero, 1 one, 2 alternating from 1, 3 every 4th, 4 random, 5 first nine samples
  function automatic logic gen(input int kind, input int k);
    case (kind)
      0: return 1'b0;
      1: return 1'b1;
      2: return (k % 2) == 1;
      3: return (k % 4) == 0;
      4: return 1'($urandom);
      default: return k <= 9;
    endcase
  endfunction

  // Called at a negedge; start is raised so the next posedge is the start edge
  task automatic run_win(input vec_t v);
    int cnt[4];
    logic b;
    cnt = '{0, 0, 0, 0};
    start = 1'b1;
    a = 4'($urandom);
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      chk("busy_during", int'(busy), 1);
      chk("valid_during", int'(valid), 0);
      start = v.hold ? 1'b1 : (k == v.mid);
      for (int e = 0; e < 4; e++) begin
        b = gen(v.kind[e], k);
        a[e/2][e%2] = b;
        cnt[e] += int'(b);
      end
    end
    @(negedge CLK);
    chk("valid_done", int'(valid), 1);
    chk("busy_done", int'(busy), 0);
    for (int e = 0; e < 4; e++) begin
      chk("y_model", int'(y[e/2][e%2]), cnt[e]);
      if (v.ex[e] >= 0) chk("y_table", int'(y[e/2][e%2]), v.ex[e]);
    end
    start = v.hold;
    if (!v.hold) begin
      @(negedge CLK);
      chk("valid_fall", int'(valid), 0);
      chk("busy_idle", int'(busy), 0);
    end
  endtask

  initial begin
    vec_t nine;
    int errs, ws, we, wins, vbad, bbad;
    logic [2:0] prev, cur;
    vecs[0] = '{kind: '{1, 1, 1, 1}, ex: '{16, 16, 16, 16}, hold: 1'b0, mid: 0};
    vecs[1] = '{kind: '{0, 2, 3, 1}, ex: '{0, 8, 4, 16},    hold: 1'b0, mid: 0};
    vecs[2] = '{kind: '{4, 4, 4, 4}, ex: '{-1, -1, -1, -1}, hold: 1'b0, mid: 0};
    vecs[3] = '{kind: '{2, 1, 0, 3}, ex: '{8, 16, 0, 4},    hold: 1'b0, mid: 5};
    vecs[4] = '{kind: '{1, 0, 2, 3}, ex: '{16, 0, 8, 4},    hold: 1'b1, mid: 0};
    vecs[5] = '{kind: '{3, 2, 1, 0}, ex: '{4, 8, 16, 0},    hold: 1'b0, mid: 0};
    nine    = '{kind: '{5, 5, 5, 5}, ex: '{9, 9, 9, 9},     hold: 1'b0, mid: 0};
    nRST = 1'b0; start = 1'b0; start2 = 1'b0; a = '0; a2 = '0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    for (int e = 0; e < 4; e++) chk("rst_y", int'(y[e/2][e%2]), 0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int v = 0; v < 6; v++) run_win(vecs[v]);
    // Abort a window after six samples with an asynchronous reset
    run_win(nine);
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      start = 1'b0;
      a = 4'hF;
    end
    #2 nRST = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(valid), 0);
    for (int e = 0; e < 4; e++) chk("abort_y", int'(y[e/2][e%2]), 0);
    @(negedge CLK);
    nRST = 1'b1;
    run_win(vecs[0]);
    run_win(nine);
    errs = 0;
    for (int k = 0; k < 50; k++) begin
      a = 4'($urandom);
      @(negedge CLK);
      for (int e = 0; e < 4; e++) errs += int'(y[e/2][e%2] !== 5'd9);
      errs += int'(valid !== 1'b0) + int'(busy !== 1'b0);
    end
    chk("hold_errors", errs, 0);
    chk("hold_y00", int'(y[0][0]), 9);
    ws = -10; we = -1; wins = 0; vbad = 0; bbad = 0; cur = '0;
    for (int c = 0; c < 3000 && wins < 100; c++) begin
      start2 = 1'($urandom);
      a2 = 3'($urandom);
      if (c > we && start2) begin ws = c; we = c + 2; end
      prev = cur;
      cur = a2;
      @(negedge CLK);
      vbad += int'(valid2 !== (c == we));
      bbad += int'(busy2 !== (c >= ws && c < we));
      if (c == we) begin
        wins++;
        for (int i = 0; i < 3; i++) chk("sweep_y", int'(y2[i][0]), int'(prev[i]) + int'(cur[i]));
      end
    end
    chk("sweep_windows", wins, 100);
    chk("sweep_valid_errors", vbad, 0);
    chk("sweep_busy_errors", bbad, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
